// File: rtl/uart_fft_loader_pkg.sv
// Shared types and constants for the UART-to-FFT frame loader.
package uart_fft_loader_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_LOAD      = 2'd1,
        ST_CHECK     = 2'd2,
        ST_WAIT_DONE = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        ERR_NONE    = 2'b00,
        ERR_CKSUM   = 2'b01,
        ERR_TRUNC   = 2'b10,
        ERR_OVERRUN = 2'b11
    } err_e;

    localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

endpackage

// File: rtl/uart_fft_loader_packer.sv
// Assembles little-endian samples from a byte stream; word_valid_o fires
// combinationally on the byte that completes a sample.
module uart_byte_packer #(
    parameter int unsigned SAMPLE_WIDTH = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clear_i,
    input  logic                    byte_valid_i,
    input  logic [7:0]              byte_i,
    output logic                    word_valid_o,
    output logic [SAMPLE_WIDTH-1:0] word_o
);

    localparam int unsigned BPS = SAMPLE_WIDTH / 8;

    logic [1:0]              idx_q, idx_d;
    logic [SAMPLE_WIDTH-1:0] word_q, word_d;

    always_comb begin
        idx_d        = idx_q;
        word_d       = word_q;
        word_valid_o = 1'b0;
        if (clear_i) begin
            idx_d  = '0;
            word_d = '0;
        end else if (byte_valid_i) begin
            word_d[8*int'(idx_q) +: 8] = byte_i;
            if (idx_q == 2'(BPS - 1)) begin
                idx_d        = '0;
                word_valid_o = 1'b1;
            end else begin
                idx_d = idx_q + 2'd1;
            end
        end
    end

    // The completing byte is merged before the register so the word is usable this cycle.
    assign word_o = word_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q  <= '0;
            word_q <= '0;
        end else begin
            idx_q  <= idx_d;
            word_q <= word_d;
        end
    end

endmodule

// File: rtl/uart_fft_loader.sv
// Frame sequencer: sync hunt, sample loading into the FFT buffer, XOR checksum
// verification and FFT handshake.
module uart_fft_loader
    import uart_fft_loader_pkg::*;
#(
    parameter int unsigned N_POINTS     = 256,
    parameter int unsigned SAMPLE_WIDTH = 16,
    parameter logic [7:0]  SYNC_BYTE    = DEFAULT_SYNC_BYTE,
    localparam int unsigned ADDR_W      = $clog2(N_POINTS)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    rx_data_ready,
    input  logic [7:0]              rx_data,
    input  logic                    rx_endofpacket,
    output logic                    wr_en,
    output logic [ADDR_W-1:0]       wr_addr,
    output logic [SAMPLE_WIDTH-1:0] wr_data,
    output logic                    fft_start,
    input  logic                    fft_done,
    output logic                    busy,
    output logic                    frame_ok,
    output logic                    frame_err,
    output logic [1:0]              err_code
);

    state_e                  state_q, state_d;
    err_e                    err_code_q, err_code_d;
    logic [ADDR_W-1:0]       addr_q, addr_d, wr_addr_q, wr_addr_d;
    logic [SAMPLE_WIDTH-1:0] wr_data_q, wr_data_d;
    logic [7:0]              chk_q, chk_d;
    logic                    wr_en_q, wr_en_d, fft_start_q, fft_start_d;
    logic                    frame_ok_q, frame_ok_d, frame_err_q, frame_err_d;
    logic                    busy_q, busy_d;
    logic                    pack_clear, pack_valid, word_valid;
    logic [SAMPLE_WIDTH-1:0] word;

    uart_byte_packer #(.SAMPLE_WIDTH(SAMPLE_WIDTH)) u_packer (
        .clk          (clk),
        .rst          (rst),
        .clear_i      (pack_clear),
        .byte_valid_i (pack_valid),
        .byte_i       (rx_data),
        .word_valid_o (word_valid),
        .word_o       (word)
    );

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        chk_d       = chk_q;
        wr_en_d     = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        fft_start_d = 1'b0;
        frame_ok_d  = 1'b0;
        frame_err_d = 1'b0;
        err_code_d  = err_code_q;
        pack_clear  = 1'b1;
        pack_valid  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                addr_d = '0;
                chk_d  = '0;
                if (rx_data_ready && rx_data == SYNC_BYTE) state_d = ST_LOAD;
            end
            ST_LOAD: begin
                pack_clear = 1'b0;
                if (rx_endofpacket) begin
                    frame_err_d = 1'b1;
                    err_code_d  = ERR_TRUNC;
                    state_d     = ST_IDLE;
                end else if (rx_data_ready) begin
                    pack_valid = 1'b1;
                    chk_d      = chk_q ^ rx_data;
                    if (word_valid) begin
                        wr_en_d   = 1'b1;
                        wr_addr_d = addr_q;
                        wr_data_d = word;
                        addr_d    = addr_q + 1'b1;
                        if (addr_q == ADDR_W'(N_POINTS - 1)) state_d = ST_CHECK;
                    end
                end
            end
            ST_CHECK: begin
                if (rx_endofpacket) begin
                    frame_err_d = 1'b1;
                    err_code_d  = ERR_TRUNC;
                    state_d     = ST_IDLE;
                end else if (rx_data_ready) begin
                    if (rx_data == chk_q) begin
                        fft_start_d = 1'b1;
                        frame_ok_d  = 1'b1;
                        state_d     = ST_WAIT_DONE;
                    end else begin
                        frame_err_d = 1'b1;
                        err_code_d  = ERR_CKSUM;
                        state_d     = ST_IDLE;
                    end
                end
            end
            ST_WAIT_DONE: begin
                if (rx_data_ready) begin
                    frame_err_d = 1'b1;
                    err_code_d  = ERR_OVERRUN;
                end
                // A done pulse landing with our own start pulse cannot belong to this frame.
                if (fft_done && !fft_start_q) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            chk_q       <= '0;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            fft_start_q <= 1'b0;
            frame_ok_q  <= 1'b0;
            frame_err_q <= 1'b0;
            err_code_q  <= ERR_NONE;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            chk_q       <= chk_d;
            wr_en_q     <= wr_en_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            fft_start_q <= fft_start_d;
            frame_ok_q  <= frame_ok_d;
            frame_err_q <= frame_err_d;
            err_code_q  <= err_code_d;
            busy_q      <= busy_d;
        end
    end

    assign wr_en     = wr_en_q;
    assign wr_addr   = wr_addr_q;
    assign wr_data   = wr_data_q;
    assign fft_start = fft_start_q;
    assign frame_ok  = frame_ok_q;
    assign frame_err = frame_err_q;
    assign err_code  = err_code_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_uart_fft_loader.sv
// Directed bench for uart_fft_loader with a 4-point, 16-bit frame configuration.
module tb_uart_fft_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rx_data_ready = 1'b0;
    logic [7:0]  rx_data = '0;
    logic        rx_endofpacket = 1'b0;
    logic        fft_done = 1'b0;
    logic        wr_en, fft_start, busy, frame_ok, frame_err;
    logic [1:0]  wr_addr, err_code;
    logic [15:0] wr_data;

    int n_tests = 0;
    int n_fail  = 0;

    // Cumulative event log gathered away from the active edge.
    int          nw = 0, nstart = 0, nok = 0, nerr = 0;
    logic [1:0]  wa [64];
    logic [15:0] wd [64];

    uart_fft_loader #(
        .N_POINTS     (4),
        .SAMPLE_WIDTH (16),
        .SYNC_BYTE    (8'hA5)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .rx_data_ready  (rx_data_ready),
        .rx_data        (rx_data),
        .rx_endofpacket (rx_endofpacket),
        .wr_en          (wr_en),
        .wr_addr        (wr_addr),
        .wr_data        (wr_data),
        .fft_start      (fft_start),
        .fft_done       (fft_done),
        .busy           (busy),
        .frame_ok       (frame_ok),
        .frame_err      (frame_err),
        .err_code       (err_code)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (wr_en) begin
            if (nw < 64) begin
                wa[nw] = wr_addr;
                wd[nw] = wr_data;
            end
            nw = nw + 1;
        end
        if (fft_start) nstart = nstart + 1;
        if (frame_ok)  nok    = nok + 1;
        if (frame_err) nerr   = nerr + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        rx_data       = b;
        rx_data_ready = 1'b1;
        tick();
        rx_data_ready = 1'b0;
        tick();
        tick();
    endtask

    task automatic send_samples();
        send(8'h01); send(8'h00); send(8'h02); send(8'h00);
        send(8'h03); send(8'h00); send(8'h04); send(8'h00);
    endtask

    task automatic check_four_writes(input string tag, input int base);
        check({tag, "_wcount"}, 32'(nw - base), 32'd4);
        for (int i = 0; i < 4; i++) begin
            check({tag, "_waddr"}, 32'(wa[base+i]), 32'(i));
            check({tag, "_wdata"}, 32'(wd[base+i]), 32'(i + 1));
        end
    endtask

    task automatic pulse_done();
        fft_done = 1'b1;
        tick();
        fft_done = 1'b0;
        tick();
    endtask

    int b_w, b_s, b_o, b_e;

    task automatic snap();
        b_w = nw; b_s = nstart; b_o = nok; b_e = nerr;
    endtask

    initial begin
        tick(); tick();
        rst = 1'b0;
        tick();
        check("rst_wr_en", 32'(wr_en), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_err_code", 32'(err_code), 32'd0);
        check("rst_fft_start", 32'(fft_start), 32'd0);
        check("rst_wr_data", 32'(wr_data), 32'd0);

        // Test 1: good frame, with latency checks on the last sample and check bytes.
        snap();
        send(8'hA5);
        send(8'h01); send(8'h00); send(8'h02); send(8'h00);
        send(8'h03); send(8'h00); send(8'h04);
        rx_data = 8'h00; rx_data_ready = 1'b1;
        tick();
        rx_data_ready = 1'b0;
        check("t1_wr_lat", 32'(wr_en), 32'd1);
        tick(); tick();
        check("t1_busy_load", 32'(busy), 32'd1);
        rx_data = 8'h04; rx_data_ready = 1'b1;
        tick();
        rx_data_ready = 1'b0;
        check("t1_start_lat", 32'(fft_start), 32'd1);
        check("t1_ok_lat", 32'(frame_ok), 32'd1);
        tick(); tick(); tick();
        check_four_writes("t1", b_w);
        check("t1_nstart", 32'(nstart - b_s), 32'd1);
        check("t1_nok", 32'(nok - b_o), 32'd1);
        check("t1_nerr", 32'(nerr - b_e), 32'd0);
        check("t1_busy_wait", 32'(busy), 32'd1);
        pulse_done();
        check("t1_busy_idle", 32'(busy), 32'd0);

        // Test 2: checksum mismatch.
        snap();
        send(8'hA5); send_samples(); send(8'h05);
        check_four_writes("t2", b_w);
        check("t2_nerr", 32'(nerr - b_e), 32'd1);
        check("t2_err_code", 32'(err_code), 32'd1);
        check("t2_nstart", 32'(nstart - b_s), 32'd0);
        check("t2_busy", 32'(busy), 32'd0);

        // Test 3: truncation, then a fresh frame restarts at address 0.
        snap();
        send(8'hA5); send(8'h01); send(8'h00); send(8'h02);
        rx_endofpacket = 1'b1;
        tick();
        rx_endofpacket = 1'b0;
        tick();
        check("t3_wcount", 32'(nw - b_w), 32'd1);
        check("t3_waddr", 32'(wa[b_w]), 32'd0);
        check("t3_wdata", 32'(wd[b_w]), 32'h0001);
        check("t3_nerr", 32'(nerr - b_e), 32'd1);
        check("t3_err_code", 32'(err_code), 32'd2);
        check("t3_busy", 32'(busy), 32'd0);
        snap();
        send(8'hA5); send_samples(); send(8'h04);
        check_four_writes("t3b", b_w);
        check("t3b_nstart", 32'(nstart - b_s), 32'd1);
        pulse_done();
        check("t3b_busy", 32'(busy), 32'd0);

        // Test 4: garbage ahead of the sync byte; left in WAIT_DONE for test 5.
        snap();
        send(8'h00); send(8'hFF); send(8'h5A);
        check("t4_busy_hunt", 32'(busy), 32'd0);
        send(8'hA5); send_samples(); send(8'h04);
        check_four_writes("t4", b_w);
        check("t4_nstart", 32'(nstart - b_s), 32'd1);
        check("t4_nok", 32'(nok - b_o), 32'd1);
        check("t4_nerr", 32'(nerr - b_e), 32'd0);

        // Test 5: overrun while waiting for the FFT.
        snap();
        send(8'h7E);
        check("t5_nerr", 32'(nerr - b_e), 32'd1);
        check("t5_err_code", 32'(err_code), 32'd3);
        check("t5_busy", 32'(busy), 32'd1);
        check("t5_nwrites", 32'(nw - b_w), 32'd0);
        pulse_done();
        check("t5_busy_idle", 32'(busy), 32'd0);

        // Test 6: reset mid-frame, recovery, then eop coinciding with a byte.
        send(8'hA5); send(8'h01); send(8'h00); send(8'h02);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t6_rst_busy", 32'(busy), 32'd0);
        check("t6_rst_err_code", 32'(err_code), 32'd0);
        check("t6_rst_wr_addr", 32'(wr_addr), 32'd0);
        check("t6_rst_wr_data", 32'(wr_data), 32'd0);
        tick();
        snap();
        send(8'hA5); send_samples(); send(8'h04);
        check_four_writes("t6", b_w);
        check("t6_nstart", 32'(nstart - b_s), 32'd1);
        pulse_done();
        snap();
        send(8'hA5); send(8'h01);
        rx_data = 8'h00; rx_data_ready = 1'b1; rx_endofpacket = 1'b1;
        tick();
        rx_data_ready = 1'b0; rx_endofpacket = 1'b0;
        tick(); tick();
        check("t6_coinc_nw", 32'(nw - b_w), 32'd0);
        check("t6_coinc_err_code", 32'(err_code), 32'd2);
        check("t6_coinc_nerr", 32'(nerr - b_e), 32'd1);
        check("t6_coinc_busy", 32'(busy), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
